// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the register-count / checksum-index constants.
package reg_dump_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int          NUM_REGS     = 32;
    localparam logic [5:0]  CKSUM_IDX    = 6'd32;
    localparam logic [4:0]  LAST_REG_IDX = 5'(NUM_REGS - 1);

endpackage

// File: rtl/reg_dump_reader.sv
// Register-file dump reader: walks x0..x31 through a zero-latency read port
// and streams each word out over a valid/ready beat interface.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append a 33rd beat
// (index 32) carrying the XOR of all 32 captured words.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic         busy_o,
    output logic [4:0]   rf_rd_addr_o,
    input  logic [N-1:0] rf_rd_data_i,
    output logic         dump_valid_o,
    input  logic         dump_ready_i,
    output logic [N-1:0] dump_data_o,
    output logic [5:0]   dump_idx_o,
    output logic         dump_last_o,
    output logic         done_o
);

    state_t       state_reg;
    logic [4:0]   index_reg;
    logic [N-1:0] data_reg;
    logic [5:0]   idx_reg;
    logic         valid_reg;
    logic         last_reg;
    logic         done_reg;
    logic         handshake;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [N-1:0] cksum_reg;
    // Set once the index-31 beat has been accepted; the next capture loads
    // the checksum instead of a register word.
    logic         cksum_phase_reg;
`endif

    // Beat accepted this cycle; valid is purely registered, ready only
    // steers the next state.
    assign handshake = valid_reg & dump_ready_i;

    assign busy_o       = (state_reg != ST_IDLE);
    assign rf_rd_addr_o = index_reg;
    assign dump_valid_o = valid_reg;
    assign dump_data_o  = data_reg;
    assign dump_idx_o   = idx_reg;
    assign dump_last_o  = last_reg;
    assign done_o       = done_reg;

    // Dump sequencer: FSM, index counter and all beat output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            index_reg <= 5'd0;
            data_reg  <= '0;
            idx_reg   <= 6'd0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            cksum_reg       <= '0;
            cksum_phase_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        index_reg <= 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                        cksum_reg       <= '0;
                        cksum_phase_reg <= 1'b0;
`endif
                        state_reg <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    valid_reg <= 1'b1;
                    state_reg <= ST_SEND;
`ifdef REG_DUMP_CHECKSUM_EN
                    if (cksum_phase_reg) begin
                        data_reg <= cksum_reg;
                        idx_reg  <= CKSUM_IDX;
                        last_reg <= 1'b1;
                    end else begin
                        data_reg  <= rf_rd_data_i;
                        idx_reg   <= {1'b0, index_reg};
                        last_reg  <= 1'b0;
                        cksum_reg <= cksum_reg ^ rf_rd_data_i;
                    end
`else
                    data_reg <= rf_rd_data_i;
                    idx_reg  <= {1'b0, index_reg};
                    last_reg <= (index_reg == LAST_REG_IDX);
`endif
                end

                ST_SEND: begin
                    // Payload registers are untouched here, so they hold
                    // stable for as long as the sink stalls.
                    if (handshake) begin
                        valid_reg <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                        if (cksum_phase_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else if (index_reg == LAST_REG_IDX) begin
                            cksum_phase_reg <= 1'b1;
                            state_reg       <= ST_CAPTURE;
                        end else begin
                            index_reg <= index_reg + 5'd1;
                            state_reg <= ST_CAPTURE;
                        end
`else
                        if (index_reg == LAST_REG_IDX) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            index_reg <= index_reg + 5'd1;
                            state_reg <= ST_CAPTURE;
                        end
`endif
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader. Compile with REG_DUMP_CHECKSUM_EN
// defined to also exercise the checksum beat.
module tb_reg_dump_reader;

    localparam int N = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int TIMEOUT = 1000;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic         busy;
    logic [4:0]   addr;
    logic [N-1:0] rdata;
    logic         valid;
    logic [N-1:0] data;
    logic [5:0]   idx;
    logic         last;
    logic         done;

    logic [N-1:0] rf [32];
    assign rdata = rf[addr];

    always #5 clk = ~clk;

    reg_dump_reader #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .busy_o       (busy),
        .rf_rd_addr_o (addr),
        .rf_rd_data_i (rdata),
        .dump_valid_o (valid),
        .dump_ready_i (ready),
        .dump_data_o  (data),
        .dump_idx_o   (idx),
        .dump_last_o  (last),
        .done_o       (done)
    );

    int checks   = 0;
    int failures = 0;

    // Expected beat stream, derived from the register contents alone.
    logic [N-1:0] exp_data [$];
    int           exp_idx  [$];
    bit           exp_last [$];
    logic [N-1:0] cksum_beat_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_expected();
        logic [N-1:0] x;
        x = '0;
        exp_data.delete();
        exp_idx.delete();
        exp_last.delete();
        for (int i = 0; i < 32; i++) begin
            exp_data.push_back(rf[i]);
            exp_idx.push_back(i);
            exp_last.push_back(!CK && (i == 31));
            x = x ^ rf[i];
        end
        if (CK) begin
            exp_data.push_back(x);
            exp_idx.push_back(32);
            exp_last.push_back(1'b1);
        end
    endtask

    // mode 0: ready high, 1: ready toggles each cycle, 2: random ready.
    // restart_beat >= 0 pulses start on that beat's handshake cycle.
    task automatic run_dump(input int mode, input int restart_beat);
        int k, beat, done_count, first_valid_k, done_k;
        logic sv, sl, hs;
        logic [N-1:0] sd;
        logic [5:0] si;
        build_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        check("busy_after_start", busy, 1);
        beat = 0; done_count = 0; first_valid_k = -1; done_k = -1;
        while (!(done_count > 0 && !busy) && k < TIMEOUT) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (k % 2 == 1);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            sv = valid; sd = data; si = idx; sl = last;
            hs = valid && ready;
            if (sv && first_valid_k < 0) first_valid_k = k;
            if (hs && beat == restart_beat) start = 1'b1;
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (hs) begin
                if (beat < exp_data.size()) begin
                    $display("beat %0d idx=%0d data=%h last=%0b cycle=%0d", beat, si, sd, sl, k);
                    check("beat_data", sd, exp_data[beat]);
                    check("beat_idx", si, exp_idx[beat]);
                    check("beat_last", sl, exp_last[beat]);
                    if (si == 6'd32) cksum_beat_data = sd;
                end else begin
                    check("extra_beat", beat, exp_data.size());
                end
                beat++;
                check("valid_drops_after_hs", valid, 0);
            end else if (sv) begin
                check("stall_valid", valid, 1);
                check("stall_data", data, sd);
                check("stall_idx", idx, si);
                check("stall_last", last, sl);
            end
            if (done) begin
                done_count++;
                if (done_k < 0) done_k = k;
            end
        end
        check("dump_timeout", (k < TIMEOUT), 1);
        check("beat_count", beat, exp_data.size());
        check("done_count", done_count, 1);
        if (mode == 0) begin
            check("first_valid_cycle", first_valid_k, 2);
            check("done_cycle", done_k, 2 * exp_data.size() + 1);
        end
        // No restart and nothing queued after the dump.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_valid", valid, 0);
            check("idle_done", done, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        cksum_beat_data = '0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        check("rst_idx", idx, 0);
        check("rst_addr", addr, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", busy, 0);

        // xK = K*0x11111111, ready high
        for (int i = 0; i < 32; i++) rf[i] = N'(i * 64'h11111111);
        run_dump(0, -1);

        // Same preload, ready toggling
        run_dump(1, -1);

        // Second start while busy at beat 10
        run_dump(0, 10);

        // Reset mid-dump while beat 15 is stalled
        for (int i = 0; i < 32; i++) rf[i] = N'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (valid && idx == 6'd15) break;
            @(posedge clk); #1;
        end
        ready = 1'b0;
        check("reached_beat15_valid", valid, 1);
        check("reached_beat15_idx", idx, 15);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_done", done, 0);
        check("abort_addr", addr, 0);
        check("abort_idx", idx, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
            check("abort_stays_idle", busy, 0);
        end
        run_dump(0, -1);

        // Random contents, random back-pressure
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) rf[i] = N'($urandom);
            run_dump(2, -1);
        end

`ifdef REG_DUMP_CHECKSUM_EN
        // Checksum beat with a known XOR
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[5] = 32'hA5A5A5A5;
        rf[9] = 32'h0F0F0F0F;
        run_dump(0, -1);
        check("cksum_value", cksum_beat_data, 32'hAAAAAAAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have parameter N, default 32, the register data width in bits.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 start_i  input  1  dump request, sampled in IDLE only.
REQ-005 busy_o  output  1  high in every state except IDLE.
REQ-006 rf_rd_addr_o  output  5  register-file read address; driven from the index counter.
REQ-007 rf_rd_data_i  input  N  register-file read data for rf_rd_addr_o, combinational with zero latency.
REQ-008 dump_valid_o  output  1  beat valid.
REQ-009 dump_ready_i  input  1  sink ready.
REQ-010 dump_data_o  output  N  beat payload.
REQ-011 dump_idx_o  output  6  beat index, 0-31 for registers and 32 for the checksum.
REQ-012 dump_last_o  output  1  high on the final beat of a dump.
REQ-013 done_o  output  1  one-cycle pulse after the final handshake.

Function
REQ-014 The FSM SHALL have states IDLE, CAPTURE, SEND and DONE.
REQ-015 IDLE with start_i=1: clear the index to 0, then go to CAPTURE; start_i=0: stay in IDLE.
REQ-016 CAPTURE: register rf_rd_data_i into the data register, set dump_valid_o, then go to SEND; the state lasts exactly one cycle.
REQ-017 SEND: dump_data_o, dump_idx_o and dump_last_o SHALL hold stable while dump_valid_o=1 and dump_ready_i=0.
REQ-018 A handshake SHALL occur on a cycle with dump_valid_o=1 and dump_ready_i=1; dump_valid_o deasserts in the following cycle.
REQ-019 On a handshake with index<31: increment the index and go to CAPTURE.
REQ-020 On a handshake with index=31: go to DONE, or to the checksum beat per REQ-030.
REQ-021 DONE: assert done_o for exactly one cycle, then return to IDLE.
REQ-022 First dump_valid_o SHALL assert 2 cycles after start_i is sampled; with ready held high, each beat takes 2 cycles, for 64 cycles from start to done_o.
REQ-023 start_i while busy_o=1 SHALL be ignored, with no restart and no queuing.
REQ-024 Register x0 SHALL be read and sent like any other register; no special casing.
REQ-025 The index SHALL NOT wrap past 31; no state may increment from 31.
REQ-026 dump_valid_o SHALL NOT depend combinationally on dump_ready_i.

Reset
REQ-027 When rst=0 at a clock edge, the state SHALL become IDLE regardless of the current state, including mid-dump.
REQ-028 The reset values SHALL be:
- index = 0, so rf_rd_addr_o = 0
- dump_valid_o, dump_last_o, done_o and busy_o = 0
- dump_data_o, dump_idx_o and the checksum = 0
REQ-029 A dump aborted by reset SHALL NOT produce done_o; a new start_i is required.

Configuration
REQ-030 Macro REG_DUMP_CHECKSUM_EN defined:
- The block SHALL keep a running XOR of all 32 captured words.
- After the index-31 handshake it SHALL send one extra beat: data = XOR, dump_idx_o = 32, dump_last_o = 1.
- DONE follows that beat's handshake.
REQ-031 Macro undefined:
- No checksum logic is built.
- The index-31 beat carries dump_last_o = 1 and leads directly to DONE.
- dump_idx_o never exceeds 31.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state encoding type
- constant NUM_REGS = 32
- constant CKSUM_IDX = 32
REQ-033 The block SHALL be a single module with no sub-modules; the FSM, index counter and output registers live inline.

Verification
REQ-034 Reg file preloaded with xK = K*0x11111111 (truncated to N), ready tied high, start pulse → 32 beats idx 0-31 with matching data, last on idx 31, done_o 64 cycles after start.
REQ-035 Same preload, ready toggling 1/0 every cycle → data, idx and last remain stable while stalled; beat sequence and order unchanged.
REQ-036 start_i pulsed again at beat 10 → ignored; exactly 32 beats and one done_o.
REQ-037 rst=0 for one cycle while waiting on the idx-15 beat with ready low → next cycle IDLE, valid=0, no done_o; a fresh start dumps from idx 0.
REQ-038 REG_DUMP_CHECKSUM_EN defined, all regs 0 except x5=0xA5A5A5A5 and x9=0x0F0F0F0F → 33 beats; beat 32 data = 0xAAAAAAAA with last=1; beat 31 last=0.
